// File: rtl/uart_pkg.sv
// Shared constants for the UART bus bridge: register map, CON bit layout and
// TX handshake state encodings.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_RX_VALID = 0;
    localparam int CON_TX_BUSY  = 1;
    localparam int CON_RX_OVF   = 2;
    localparam int CON_TX_FULL  = 3;
    localparam int CON_RX_IE    = 4;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_BUSY = 2'd2;

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide circular FIFO with a show-ahead head. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// CPU-bus front end for a byte UART: TXD/RXD/CON registers, RX and TX FIFOs,
// and the request/acknowledge handshake towards the sender.
//
// state   | meaning
// TX_IDLE | waiting for a queued byte and an idle sender
// TX_REQ  | tx_en high, waiting for the sender to go busy
// TX_BUSY | byte handed over, waiting for the sender to return idle
module uart_bus_bridge
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status
);

    logic       rx_s1, rx_s2, rx_prev;
    logic       tx_s1, tx_s2;
    logic       rx_rise;
    logic       sel_txd, sel_rxd, sel_con;
    logic       rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] rx_head, tx_head;
    logic       rx_ovf, rx_ie;
    logic [1:0] tx_state;
    logic       tx_busy;
    logic [31:0] con_rd;
    logic       unused_wdata;

    // tx_status syncs reset to 1 so a sender mid-frame is not mistaken for a fresh ack.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b0;
            rx_s2   <= 1'b0;
            rx_prev <= 1'b0;
            tx_s1   <= 1'b1;
            tx_s2   <= 1'b1;
        end else begin
            rx_s1   <= rx_status;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            tx_s1   <= tx_status;
            tx_s2   <= tx_s1;
        end
    end

    assign rx_rise = rx_s2 & ~rx_prev;
    assign sel_txd = (addr == UART_TXD_ADDR);
    assign sel_rxd = (addr == UART_RXD_ADDR);
    assign sel_con = (addr == UART_CON_ADDR);
    assign rx_pop  = rd_en & sel_rxd & ~rx_empty;
    assign tx_push = wr_en & sel_txd;
    assign tx_pop  = (tx_state == TX_REQ) & ~tx_s2;
    assign tx_busy = ~tx_empty | (tx_state != TX_IDLE);
    assign tx_en   = (tx_state == TX_REQ);

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .push   (rx_rise),
        .pop    (rx_pop),
        .din    (rx_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .head   (rx_head)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (wdata[7:0]),
        .full   (tx_full),
        .empty  (tx_empty),
        .head   (tx_head)
    );

    // A new overflow in the same cycle as a clearing write stays visible.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf <= 1'b0;
            rx_ie  <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (rx_rise && rx_full && !rx_pop) begin
                rx_ovf <= 1'b1;
            end else if (wr_en && sel_con && wdata[CON_RX_OVF]) begin
                rx_ovf <= 1'b0;
            end
            if (wr_en && sel_con) begin
                rx_ie <= wdata[CON_RX_IE];
            end
            irq <= rx_ie & ~rx_empty;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_data  <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty && tx_s2) begin
                        tx_data  <= tx_head;
                        tx_state <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (!tx_s2) tx_state <= TX_BUSY;
                end
                TX_BUSY: begin
                    if (tx_s2) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        con_rd               = '0;
        con_rd[CON_RX_VALID] = ~rx_empty;
        con_rd[CON_TX_BUSY]  = tx_busy;
        con_rd[CON_RX_OVF]   = rx_ovf;
        con_rd[CON_TX_FULL]  = tx_full;
        con_rd[CON_RX_IE]    = rx_ie;
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (sel_rxd) begin
                rdata = {24'b0, rx_empty ? 8'h00 : rx_head};
            end else if (sel_con) begin
                rdata = con_rd;
            end
        end
    end

    assign unused_wdata = ^wdata[31:8];

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: register-level vector table,
// hand-timed corner sequences and a randomized run against a queue model.
module tb_uart_bus_bridge;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_BAD = 32'h4000_0024;

    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_RX = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        sysclk;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  rx_data;
    logic        rx_status;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;

    int n_vec = 0;
    int n_err = 0;

    vec_t tab [48];
    int   n_tab = 0;

    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    logic       m_ovf;
    logic       m_ie;

    uart_bus_bridge #(.FIFO_DEPTH(4)) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge sysclk);
        addr  = a;
        rd_en = 1'b1;
        #1 d = rdata;
        @(negedge sysclk);
        rd_en = 1'b0;
        addr  = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge sysclk);
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge sysclk);
        rx_data   = b;
        rx_status = 1'b1;
        repeat (4) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    // Idle sender: acknowledge one request, stay busy briefly, return idle.
    task automatic serve_tx(output logic [7:0] b, output logic ok);
        int c;
        c  = 0;
        ok = 1'b0;
        b  = 8'h00;
        tx_status = 1'b1;
        while (!tx_en && c < 20) begin
            @(negedge sysclk);
            c++;
        end
        if (tx_en) begin
            ok = 1'b1;
            b  = tx_data;
            tx_status = 1'b0;
            c = 0;
            while (tx_en && c < 6) begin
                @(negedge sysclk);
                c++;
            end
            if (tx_en) ok = 1'b0;
            if (tx_data !== b) ok = 1'b0;
            repeat (2) @(negedge sysclk);
            tx_status = 1'b1;
            repeat (3) @(negedge sysclk);
        end
    endtask

    function automatic logic [31:0] con_model();
        logic [31:0] v;
        v    = '0;
        v[0] = (rx_q.size() != 0);
        v[1] = (tx_q.size() != 0);
        v[2] = m_ovf;
        v[3] = (tx_q.size() == 4);
        v[4] = m_ie;
        return v;
    endfunction

    task automatic add(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        tab[n_tab] = '{op: o, addr: a, data: d, exp: e};
        n_tab++;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic        ok;
        int          c;
        int          r;
        logic        seen;

        rst_n = 1'b0; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
        rx_data = 8'h00; rx_status = 1'b0; tx_status = 1'b1;

        // Reset values
        repeat (2) @(negedge sysclk);
        addr = A_CON; rd_en = 1'b1;
        #1;
        check("reset CON", rdata, 32'h0);
        check("reset tx_en", {31'b0, tx_en}, 32'h0);
        check("reset tx_data", {24'b0, tx_data}, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        @(negedge sysclk);
        rd_en = 1'b0; addr = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // Register-level vector table
        add(OP_RD, A_CON, 0, 32'h00);
        add(OP_RD, A_RXD, 0, 32'h00);
        add(OP_RD, A_TXD, 0, 32'h00);
        add(OP_RD, A_BAD, 0, 32'h00);
        add(OP_RX, 0, 32'hA5, 0);
        add(OP_RD, A_CON, 0, 32'h01);
        add(OP_RD, A_RXD, 0, 32'hA5);
        add(OP_RD, A_CON, 0, 32'h00);
        for (int i = 1; i <= 5; i++) add(OP_RX, 0, i, 0);
        add(OP_RD, A_CON, 0, 32'h05);
        for (int i = 1; i <= 4; i++) add(OP_RD, A_RXD, 0, i);
        add(OP_RD, A_CON, 0, 32'h04);
        add(OP_RD, A_RXD, 0, 32'h00);
        add(OP_WR, A_CON, 32'h04, 0);
        add(OP_RD, A_CON, 0, 32'h00);
        add(OP_WR, A_CON, 32'h10, 0);
        add(OP_RD, A_CON, 0, 32'h10);
        add(OP_WR, A_CON, 32'hFFFF_FFEF, 0);
        add(OP_RD, A_CON, 0, 32'h00);

        for (int i = 0; i < n_tab; i++) begin
            case (tab[i].op)
                OP_RD: begin
                    bus_read(tab[i].addr, d);
                    check($sformatf("table[%0d] read 0x%08h", i, tab[i].addr), d, tab[i].exp);
                end
                OP_WR:   bus_write(tab[i].addr, tab[i].data);
                default: rx_byte(tab[i].data[7:0]);
            endcase
        end

        // Push and pop on a full RX FIFO in the same cycle
        for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i));
        @(negedge sysclk);
        rx_data = 8'h14; rx_status = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        addr = A_RXD; rd_en = 1'b1;
        #1 d = rdata;
        check("full push+pop head", d, 32'h10);
        @(negedge sysclk);
        rd_en = 1'b0; addr = '0; rx_status = 1'b0;
        repeat (3) @(negedge sysclk);
        bus_read(A_CON, d);
        check("full push+pop CON", d, 32'h01);
        for (int i = 1; i <= 4; i++) begin
            bus_read(A_RXD, d);
            check($sformatf("full push+pop drain %0d", i), d, 32'h10 + i);
        end
        bus_read(A_CON, d);
        check("full push+pop CON after drain", d, 32'h00);

        // Interrupt latency
        bus_write(A_CON, 32'h10);
        @(negedge sysclk);
        rx_data = 8'h5A; rx_status = 1'b1;
        repeat (3) @(negedge sysclk);
        check("irq on push cycle", {31'b0, irq}, 32'h0);
        @(negedge sysclk);
        check("irq one cycle after push", {31'b0, irq}, 32'h1);
        rx_status = 1'b0;
        bus_read(A_RXD, d);
        check("irq RXD data", d, 32'h5A);
        check("irq on pop cycle", {31'b0, irq}, 32'h1);
        @(negedge sysclk);
        check("irq one cycle after pop", {31'b0, irq}, 32'h0);
        repeat (3) @(negedge sysclk);
        bus_write(A_CON, 32'h00);

        // Single TX handshake
        bus_write(A_TXD, 32'h3C);
        c = 0;
        while (!tx_en && c < 4) begin @(negedge sysclk); c++; end
        check("tx_en rise", {31'b0, tx_en}, 32'h1);
        check("tx_data on request", {24'b0, tx_data}, 32'h3C);
        bus_read(A_CON, d);
        check("CON during request", d, 32'h02);
        tx_status = 1'b0;
        c = 0;
        while (tx_en && c < 3) begin @(negedge sysclk); c++; end
        check("tx_en fall", {31'b0, tx_en}, 32'h0);
        check("tx_data held while busy", {24'b0, tx_data}, 32'h3C);
        bus_read(A_CON, d);
        check("CON while sender busy", d, 32'h02);
        tx_status = 1'b1;
        c = 0;
        bus_read(A_CON, d);
        while (d[1] && c < 8) begin bus_read(A_CON, d); c++; end
        check("tx_busy clears", d, 32'h00);

        // TX FIFO full while sender is held busy
        tx_status = 1'b0;
        repeat (3) @(negedge sysclk);
        for (int i = 1; i <= 5; i++) begin
            bus_write(A_TXD, 32'h10 + i);
            bus_read(A_CON, d);
            check($sformatf("tx full CON after write %0d", i), d, (i >= 4) ? 32'h0A : 32'h02);
        end
        for (int i = 1; i <= 4; i++) begin
            serve_tx(b, ok);
            check($sformatf("tx full handshake %0d", i), {31'b0, ok}, 32'h1);
            check($sformatf("tx full byte %0d", i), {24'b0, b}, 32'h10 + i);
        end
        seen = 1'b0;
        repeat (12) begin @(negedge sysclk); if (tx_en) seen = 1'b1; end
        check("tx full 5th byte not sent", {31'b0, seen}, 32'h0);
        bus_read(A_CON, d);
        check("tx full CON idle", d, 32'h00);

        // Randomized traffic against the queue model (sender held busy)
        m_ovf = 1'b0; m_ie = 1'b0;
        tx_status = 1'b0;
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                b = 8'($urandom);
                rx_byte(b);
                if (rx_q.size() == 4) m_ovf = 1'b1;
                else rx_q.push_back(b);
            end else if (r <= 4) begin
                bus_read(A_RXD, d);
                check($sformatf("rand[%0d] RXD", i), d,
                      (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0);
            end else if (r == 5) begin
                bus_read(A_CON, d);
                check($sformatf("rand[%0d] CON", i), d, con_model());
            end else if (r == 6) begin
                d = $urandom;
                bus_write(A_CON, d);
                m_ie = d[4];
                if (d[2]) m_ovf = 1'b0;
            end else if (r <= 8) begin
                b = 8'($urandom);
                bus_write(A_TXD, {24'($urandom), b});
                if (tx_q.size() < 4) tx_q.push_back(b);
            end else begin
                @(negedge sysclk);
                addr = A_CON; rd_en = 1'b0;
                #1 check($sformatf("rand[%0d] rdata idle", i), rdata, 32'h0);
                addr = '0;
            end
            @(negedge sysclk);
            check($sformatf("rand[%0d] irq", i), {31'b0, irq},
                  {31'b0, m_ie && (rx_q.size() != 0)});
        end
        bus_read(A_CON, d);
        check("rand final CON", d, con_model());
        while (tx_q.size() != 0) begin
            serve_tx(b, ok);
            check("rand drain handshake", {31'b0, ok}, 32'h1);
            check("rand drain byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
        end
        seen = 1'b0;
        repeat (12) begin @(negedge sysclk); if (tx_en) seen = 1'b1; end
        check("rand no extra tx", {31'b0, seen}, 32'h0);
        while (rx_q.size() != 0) begin
            bus_read(A_RXD, d);
            check("rand drain RXD", d, {24'b0, rx_q.pop_front()});
        end
        bus_write(A_CON, 32'h04);

        // Reset in the middle of a TX request
        tx_status = 1'b1;
        bus_write(A_CON, 32'h10);
        rx_byte(8'h66);
        bus_write(A_TXD, 32'h77);
        bus_write(A_TXD, 32'h88);
        c = 0;
        while (!tx_en && c < 6) begin @(negedge sysclk); c++; end
        check("mid-op tx_en before reset", {31'b0, tx_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        rx_status = 1'b1;
        addr = A_CON; rd_en = 1'b1;
        #1;
        check("mid-op tx_en in reset", {31'b0, tx_en}, 32'h0);
        check("mid-op tx_data in reset", {24'b0, tx_data}, 32'h0);
        check("mid-op irq in reset", {31'b0, irq}, 32'h0);
        check("mid-op CON in reset", rdata, 32'h0);
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        #1;
        check("CON first cycle after release", rdata, 32'h0);
        check("tx_en after release", {31'b0, tx_en}, 32'h0);
        rd_en = 1'b0; addr = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the entry count of each of the RX and TX FIFOs (power of two, at least 2).
REQ-002 SHALL have port sysclk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port addr, input, 32 bits: CPU bus byte address.
REQ-005 SHALL have ports rd_en and wr_en, input, 1 bit each: CPU read and write strobes, one sysclk cycle per access.
REQ-006 SHALL have port wdata, input, 32 bits: CPU write data.
REQ-007 SHALL have port rdata, output, 32 bits: combinational read data.
REQ-008 SHALL have port irq, output, 1 bit: receive interrupt.
REQ-009 SHALL have ports rx_data (input, 8 bits) and rx_status (input, 1 bit): byte and done level from the receiver, asynchronous to sysclk.
REQ-010 SHALL have ports tx_data (output, 8 bits), tx_en (output, 1 bit) and tx_status (input, 1 bit, 1 = idle): sender handshake; tx_status is asynchronous to sysclk.

Function
REQ-011 SHALL decode three word registers:
- TXD at 0x40000018: write-only; wdata[7:0] is pushed to the TX FIFO.
- RXD at 0x4000001C: read-only; returns {24'b0, RX head}; a read pops the RX FIFO.
- CON at 0x40000020: read/write.
REQ-012 SHALL lay out CON bits as follows:
- bit0: rx_valid (RX FIFO not empty), read-only.
- bit1: tx_busy (TX FIFO not empty or TX FSM not in TX_IDLE), read-only.
- bit2: rx_ovf, sticky; writing 1 clears it.
- bit3: tx_full, read-only.
- bit4: rx_ie, read/write.
- Other bits read 0.
REQ-013 SHALL drive rdata to 0 whenever rd_en=0 or addr does not match RXD or CON.
REQ-014 SHALL pass rx_status and tx_status through 2-flop synchronizers before any use.
REQ-015 SHALL detect a 0->1 edge on synchronized rx_status and, on that edge, push rx_data into the RX FIFO (3 cycles after the input edge).
REQ-016 SHALL drop the byte and set rx_ovf when the RX FIFO is full and no pop occurs in the same cycle.
REQ-017 SHALL accept both operations when a push and a pop hit a full FIFO in the same cycle; the count stays at FIFO_DEPTH.
REQ-018 SHALL treat an RXD read while the RX FIFO is empty as returning 0, with no pop and no error.
REQ-019 SHALL drop a TXD write while the TX FIFO is full, leaving state unchanged.
REQ-020 SHALL implement the TX FSM as follows:
- TX_IDLE -> TX_REQ when the TX FIFO is non-empty and synced tx_status=1; tx_data is loaded from the FIFO head.
- TX_REQ holds tx_en=1 until synced tx_status=0, then deasserts tx_en, pops the FIFO and goes to TX_BUSY.
- TX_BUSY -> TX_IDLE when synced tx_status=1.
REQ-021 SHALL hold tx_data stable from entry into TX_REQ until exit from TX_BUSY.
REQ-022 SHALL assert tx_en only in TX_REQ.
REQ-023 SHALL drive irq = rx_ie AND rx_valid, registered (one cycle of latency).
REQ-024 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH, with a count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-025 SHALL, while rst_n=0, immediately force the following, independent of sysclk:
- both FIFOs empty;
- TX FSM in TX_IDLE;
- tx_en=0, tx_data=0, irq=0;
- rx_ovf=0, rx_ie=0;
- synchronizer flops at 0, with the tx_status flops at 1.
REQ-026 SHALL, if reset arrives mid-frame, drop tx_en at once, lose the queued bytes, and let the sender finish its current frame on its own.
REQ-027 SHALL not detect an rx edge in the first cycle after reset release if rx_status is already 1.

Structure
REQ-028 SHALL keep the register addresses, CON bit indices and TX FSM state encodings in the shared package uart_pkg.
REQ-029 SHALL use one sub-module, uart_fifo (parameterised depth, 8 bits wide, push/pop/full/empty/head), instantiated twice.

Verification
REQ-030 SHALL cover RX: rx_data=0xA5 with rx_status rising -> CON reads 0x01, RXD reads 0x000000A5, then CON reads 0x00.
REQ-031 SHALL cover RX overflow: 5 rx edges (0x01..0x05) with no reads -> CON bit2=1; RXD reads 0x01..0x04; writing CON=0x04 clears bit2.
REQ-032 SHALL cover TX: write TXD=0x3C -> tx_en rises within 4 cycles with tx_data=0x3C; model drops tx_status -> tx_en falls within 3 cycles; tx_busy clears after tx_status returns to 1.
REQ-033 SHALL cover TX full: write 5 bytes while the sender is held busy -> CON bit3=1 after the 4th write, and the 5th byte is never transmitted.
REQ-034 SHALL cover the interrupt: CON=0x10, then one rx byte -> irq=1 one cycle after the push; irq=0 one cycle after RXD is read.
REQ-035 SHALL cover reset mid-operation: rst_n low during TX_REQ -> tx_en=0 without a clock edge; both FIFOs empty after release.
